sigmoid_unit: RTL and testbench

Fixed-point logistic-sigmoid activation for the two-neuron MLP datapath, placed after each neuron's weighted-sum accumulator. It takes a signed Q(DATA_WIDTH-4).4 pre-activation and evaluates σ(x) with a four-segment piecewise-linear (PLAN) approximation built from shifts and adds only. It returns σ(x) in Q(2·DATA_WIDTH-8).8 format through one output register.

---
 rtl/sigmoid_unit_if.sv | 24 ++
 rtl/sigmoid_unit.sv | 70 +++++++
 tb/tb_sigmoid_unit.sv | 115 +++++++++++
 3 files changed

// File: rtl/sigmoid_unit_if.sv
// Sample/result bus for the sigmoid activation: valid-qualified
// pre-activation in, valid-qualified sigma(x) out.
interface sigmoid_unit_if #(
  parameter int DATA_WIDTH = 8
);
  logic                      in_valid;
  logic [DATA_WIDTH-1:0]     inp;
  logic                      out_valid;
  logic [2*DATA_WIDTH-1:0]   out;

  modport master (
    output in_valid,
    output inp,
    input  out_valid,
    input  out
  );

  modport slave (
    input  in_valid,
    input  inp,
    output out_valid,
    output out
  );
endinterface

// File: rtl/sigmoid_unit.sv
// Four-segment piecewise-linear logistic sigmoid: Q.4 signed in, Q.8 out,
// shifts/adds only, one registered output stage.
module sigmoid_unit #(
  parameter int DATA_WIDTH = 8
) (
  input logic          clk,
  input logic          rst,
  sigmoid_unit_if.slave bus
);
  localparam int AW = DATA_WIDTH + 1;
  localparam int OW = 2 * DATA_WIDTH;

  logic [AW-1:0] inp_sx;
  logic [AW-1:0] a;
  logic [OW-1:0] a_ext;
  logic [OW-1:0] p;
  logic [OW-1:0] y;

  logic [OW-1:0] out_d, out_q;
  logic          out_valid_d, out_valid_q;

  // |x| in one extra bit so the most-negative input stays representable
  always_comb begin
    inp_sx = {bus.inp[DATA_WIDTH-1], bus.inp};
    a      = inp_sx;
    if (bus.inp[DATA_WIDTH-1]) begin
      a = ~inp_sx + AW'(1);
    end
    a_ext = OW'(a);
  end

  always_comb begin
    p = OW'(256);
    if (a_ext >= OW'(80)) begin
      p = OW'(256);
    end else if (a_ext >= OW'(38)) begin
      p = OW'(216) + (a_ext >> 1);
    end else if (a_ext >= OW'(16)) begin
      p = OW'(160) + (a_ext << 1);
    end else begin
      p = OW'(128) + (a_ext << 2);
    end

    y = p;
    if (bus.inp[DATA_WIDTH-1]) begin
      y = OW'(256) - p;
    end
  end

  always_comb begin
    out_d       = out_q;
    out_valid_d = bus.in_valid;
    if (bus.in_valid) begin
      out_d = y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_sigmoid_unit.sv
// Directed and exhaustive checks of sigmoid_unit against hand values and
// the piecewise-linear sigmoid formula.
module tb_sigmoid_unit;
  localparam int DW = 8;
  localparam int N  = 1 << DW;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   ys [N];

  sigmoid_unit_if #(.DATA_WIDTH(DW)) bus ();

  sigmoid_unit #(.DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int plan(input int x);
    int a;
    int p;
    a = (x < 0) ? -x : x;
    if (a >= 80)      p = 256;
    else if (a >= 38) p = 216 + a / 2;
    else if (a >= 16) p = 160 + 2 * a;
    else              p = 128 + 4 * a;
    return (x < 0) ? 256 - p : p;
  endfunction

  // present one sample, clock it, then sample outputs 1 time unit later
  task automatic step(input logic v, input int x);
    bus.in_valid = v;
    bus.inp      = DW'(x);
    @(posedge clk);
    #1;
  endtask

  task automatic vec(input string tag, input int x, input int exp);
    step(1'b1, x);
    chk({tag, "_valid"}, int'(bus.out_valid), 1);
    chk(tag, int'(bus.out), exp);
  endtask

  int pos_in  [6] = '{16, 32, 48, 64, 80, 96};
  int pos_exp [6] = '{192, 224, 240, 248, 256, 256};
  int neg_in  [4] = '{-16, -32, -80, -64};
  int neg_exp [4] = '{64, 32, 0, 8};
  int bnd_in  [7] = '{0, 15, 37, 38, 79, 127, -128};
  int bnd_exp [7] = '{128, 188, 234, 235, 255, 256, 0};

  initial begin
    total = 0;
    bad   = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.inp      = DW'(16);

    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("rst_out", int'(bus.out), 0);
      chk("rst_valid", int'(bus.out_valid), 0);
    end
    rst = 1'b0;
    vec("post_rst", 16, 192);

    for (int i = 0; i < 6; i++) vec("pos", pos_in[i], pos_exp[i]);
    for (int i = 0; i < 4; i++) vec("neg", neg_in[i], neg_exp[i]);
    for (int i = 0; i < 7; i++) vec("bnd", bnd_in[i], bnd_exp[i]);

    // valid gating: idle cycle holds the previous result
    vec("gate1", 16, 192);
    step(1'b0, 48);
    chk("gate_idle_valid", int'(bus.out_valid), 0);
    chk("gate_idle_out", int'(bus.out), 192);
    vec("gate2", -16, 64);

    // mid-stream reset discards the sample on that edge
    rst = 1'b1;
    step(1'b1, 48);
    chk("mid_rst_out", int'(bus.out), 0);
    chk("mid_rst_valid", int'(bus.out_valid), 0);
    rst = 1'b0;
    vec("after_mid_rst", 48, 240);

    for (int x = -(N / 2); x < N / 2; x++) begin
      step(1'b1, x);
      ys[x + N / 2] = int'(bus.out);
      chk("exh", ys[x + N / 2], plan(x));
      chk("range", int'(ys[x + N / 2] >= 0 && ys[x + N / 2] <= 256), 1);
    end
    for (int i = 1; i < N; i++) begin
      chk("mono", int'(ys[i] >= ys[i - 1]), 1);
    end
    for (int x = -(N / 2) + 1; x < N / 2; x++) begin
      chk("sym", ys[x + N / 2] + ys[-x + N / 2], 256);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
